// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one 64-bit memory port between the instruction-fetch
//                unit (read-only) and the load/store unit (read/write). It
//                arbitrates, runs a single-cycle access, aligns the data by
//                access size and returns a buffered response.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int LSU_PRIO   = 1,
  parameter int RESET_LAST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [31:0] if_resp_inst,
  output logic        if_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_we,
  input  logic [1:0]  lsu_req_size,
  input  logic [63:0] lsu_req_addr,
  input  logic [63:0] lsu_req_wdata,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_resp_rdata,
  output logic        lsu_resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  localparam logic c_lsu_prio   = (LSU_PRIO != 0);
  localparam logic c_reset_last = (RESET_LAST != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last;   // last granted requester: 0 = IF, 1 = LSU
  logic        r_id;     // owner of the in-flight request: 0 = IF, 1 = LSU
  logic        r_we;
  logic [1:0]  r_size;
  logic [2:0]  r_lane;   // byte offset inside the dword

  logic        w_grant_lsu;
  logic        w_grant_if;
  logic        w_accept;
  logic        w_sel_we;
  logic [1:0]  w_sel_size;
  logic [63:0] w_sel_addr;
  logic [63:0] w_sel_wdata;
  logic [2:0]  w_align_mask;
  logic [7:0]  w_size_mask;
  logic        w_misalign;
  logic [63:0] w_rshift;
  logic [63:0] w_load_data;

  // Choose the winner and mux its request fields; IF behaves as a word read
  always_comb begin
    w_grant_lsu = lsu_req_valid && (!if_req_valid || c_lsu_prio || !r_last);
    w_grant_if  = if_req_valid && !w_grant_lsu;
    w_accept    = (r_state == ST_IDLE) && !reset && (w_grant_lsu || w_grant_if);
    w_sel_we    = w_grant_lsu && lsu_req_we;
    w_sel_size  = w_grant_lsu ? lsu_req_size  : 2'd2;
    w_sel_addr  = w_grant_lsu ? lsu_req_addr  : if_req_addr;
    w_sel_wdata = w_grant_lsu ? lsu_req_wdata : 64'd0;
    case (w_sel_size)
      2'd0:    begin w_align_mask = 3'b000; w_size_mask = 8'h01; end
      2'd1:    begin w_align_mask = 3'b001; w_size_mask = 8'h03; end
      2'd2:    begin w_align_mask = 3'b011; w_size_mask = 8'h0F; end
      default: begin w_align_mask = 3'b111; w_size_mask = 8'hFF; end
    endcase
    w_misalign = |(w_sel_addr[2:0] & w_align_mask);
  end

  assign if_req_ready  = w_accept && w_grant_if;
  assign lsu_req_ready = w_accept && w_grant_lsu;

  // Shift read data down to the addressed byte and zero-extend to the size
  always_comb begin
    w_rshift = mem_rdata >> {r_lane, 3'b000};
    case (r_size)
      2'd0:    w_load_data = {56'd0, w_rshift[7:0]};
      2'd1:    w_load_data = {48'd0, w_rshift[15:0]};
      2'd2:    w_load_data = {32'd0, w_rshift[31:0]};
      default: w_load_data = w_rshift;
    endcase
  end

  // Arbitration / access / response state machine with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_last         <= c_reset_last;
      r_id           <= 1'b0;
      r_we           <= 1'b0;
      r_size         <= 2'd0;
      r_lane         <= 3'd0;
      if_resp_valid  <= 1'b0;
      if_resp_inst   <= 32'd0;
      if_resp_err    <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_rdata <= 64'd0;
      lsu_resp_err   <= 1'b0;
      mem_ce         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 64'd0;
      mem_wdata      <= 64'd0;
      mem_wmask      <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id   <= w_grant_lsu;
            r_last <= w_grant_lsu;
            r_we   <= w_sel_we;
            r_size <= w_sel_size;
            r_lane <= w_sel_addr[2:0];
            if (w_misalign) begin
              // Misaligned requests answer immediately without touching memory
              r_state <= ST_RESP;
              if (w_grant_lsu) begin
                lsu_resp_valid <= 1'b1;
                lsu_resp_err   <= 1'b1;
                lsu_resp_rdata <= 64'd0;
              end else begin
                if_resp_valid <= 1'b1;
                if_resp_err   <= 1'b1;
                if_resp_inst  <= 32'd0;
              end
            end else begin
              r_state   <= ST_ACCESS;
              mem_ce    <= 1'b1;
              mem_we    <= w_sel_we;
              mem_addr  <= {w_sel_addr[63:3], 3'b000};
              mem_wmask <= w_sel_we ? (w_size_mask << w_sel_addr[2:0]) : 8'h00;
              mem_wdata <= w_sel_we ? (w_sel_wdata << {w_sel_addr[2:0], 3'b000}) : 64'd0;
            end
          end
        end
        ST_ACCESS: begin
          r_state   <= ST_RESP;
          mem_ce    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 64'd0;
          mem_wdata <= 64'd0;
          mem_wmask <= 8'd0;
          if (r_id) begin
            lsu_resp_valid <= 1'b1;
            lsu_resp_err   <= 1'b0;
            lsu_resp_rdata <= r_we ? 64'd0 : w_load_data;
          end else begin
            if_resp_valid <= 1'b1;
            if_resp_err   <= 1'b0;
            if_resp_inst  <= r_lane[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end
        ST_RESP: begin
          if ((r_id && lsu_resp_ready) || (!r_id && if_resp_ready)) begin
            r_state        <= ST_IDLE;
            if_resp_valid  <= 1'b0;
            if_resp_err    <= 1'b0;
            if_resp_inst   <= 32'd0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            lsu_resp_rdata <= 64'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a byte-masked
//                memory model, a directed LSU vector table and hand-written
//                fetch, arbitration, stall and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
  logic [63:0] if_req_addr;
  logic [31:0] if_resp_inst;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_we;
  logic [1:0]  lsu_req_size;
  logic [63:0] lsu_req_addr, lsu_req_wdata;
  logic        lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [63:0] lsu_resp_rdata;
  logic        mem_ce, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  // round-robin instance signals
  logic        rr_if_valid, rr_if_ready, rr_if_resp_valid, rr_if_resp_err;
  logic [31:0] rr_if_inst;
  logic        rr_lsu_valid, rr_lsu_ready, rr_lsu_resp_valid, rr_lsu_resp_err;
  logic [63:0] rr_lsu_rdata;
  logic        rr_mem_ce, rr_mem_we;
  logic [63:0] rr_mem_addr, rr_mem_wdata;
  logic [7:0]  rr_mem_wmask;

  mem_port_arbiter #(.LSU_PRIO(1), .RESET_LAST(0)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_resp_inst(if_resp_inst), .if_resp_err(if_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_size(lsu_req_size), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LSU_PRIO(0), .RESET_LAST(0)) dut_rr (
    .clk(clk), .reset(reset),
    .if_req_valid(rr_if_valid), .if_req_ready(rr_if_ready), .if_req_addr(64'h8000_0000),
    .if_resp_valid(rr_if_resp_valid), .if_resp_ready(1'b1),
    .if_resp_inst(rr_if_inst), .if_resp_err(rr_if_resp_err),
    .lsu_req_valid(rr_lsu_valid), .lsu_req_ready(rr_lsu_ready), .lsu_req_we(1'b0),
    .lsu_req_size(2'd3), .lsu_req_addr(64'h8000_0100), .lsu_req_wdata(64'd0),
    .lsu_resp_valid(rr_lsu_resp_valid), .lsu_resp_ready(1'b1),
    .lsu_resp_rdata(rr_lsu_rdata), .lsu_resp_err(rr_lsu_resp_err),
    .mem_ce(rr_mem_ce), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_wmask(rr_mem_wmask), .mem_rdata(64'd0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [63:0] mem [0:511];
  int          ce_count = 0;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_wmask;
  logic        cap_we;

  assign mem_rdata = (mem_ce && !mem_we) ? mem[mem_addr[11:3]] : 64'd0;

  // Byte-masked write port, preload on reset, and access capture
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 64'd0;
      mem[0] <= 64'h00100093_00000513;
    end
    if (mem_ce) begin
      ce_count  <= ce_count + 1;
      cap_addr  <= mem_addr;
      cap_we    <= mem_we;
      cap_wmask <= mem_wmask;
      cap_wdata <= mem_wdata;
      if (mem_we && !reset)
        for (int b = 0; b < 8; b++)
          if (mem_wmask[b]) mem[mem_addr[11:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // One LSU transaction; latency counts edges from handshake to resp_valid
  task automatic lsu_txn(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata,
                         output logic err, output int lat);
    int w;
    lsu_req_valid = 1'b1; lsu_req_we = we; lsu_req_size = size;
    lsu_req_addr = addr; lsu_req_wdata = wdata;
    #1;
    w = 0;
    while (!lsu_req_ready && w < 20) begin @(posedge clk); #1; w++; end
    check1("lsu_req_ready", lsu_req_ready, 1'b1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    lat = 0;
    while (!lsu_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = lsu_resp_rdata;
    err   = lsu_resp_err;
    @(posedge clk); #1;
  endtask

  task automatic if_txn(input logic [63:0] addr, output logic [31:0] inst,
                        output logic err, output int lat);
    int w;
    if_req_valid = 1'b1; if_req_addr = addr;
    #1;
    w = 0;
    while (!if_req_ready && w < 20) begin @(posedge clk); #1; w++; end
    check1("if_req_ready", if_req_ready, 1'b1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    lat = 0;
    while (!if_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    inst = if_resp_inst;
    err  = if_resp_err;
    @(posedge clk); #1;
  endtask

  // Both requesters hold 4 requests each; record grant order (1 = LSU)
  task automatic arb_run(input bit rr, output logic [7:0] seq, output int ngrant);
    int  if_left = 4;
    int  lsu_left = 4;
    int  cyc = 0;
    logic g_if, g_lsu;
    seq = 8'd0; ngrant = 0;
    while ((if_left > 0 || lsu_left > 0) && cyc < 100) begin
      if (rr) begin rr_if_valid = (if_left > 0); rr_lsu_valid = (lsu_left > 0); end
      else begin if_req_valid = (if_left > 0); lsu_req_valid = (lsu_left > 0); end
      #1;
      g_if  = rr ? rr_if_ready  : if_req_ready;
      g_lsu = rr ? rr_lsu_ready : lsu_req_ready;
      if (g_if || g_lsu) begin seq = {seq[6:0], g_lsu}; ngrant++; end
      @(posedge clk); #1;
      if (g_lsu) lsu_left--;
      if (g_if)  if_left--;
      cyc++;
    end
    rr_if_valid = 1'b0; rr_lsu_valid = 1'b0;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic        exp_ce;
    logic [7:0]  exp_mask;
    logic [63:0] exp_mwdata;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, held;
    logic [31:0] inst;
    logic        err, ok_valid, ok_stable, ok_ifr, saw_resp;
    logic [7:0]  seq;
    int          lat, c0, ng, w;

    //            we    size  addr                  wdata                  err   rdata                  ce    mask   mwdata
    vecs[0]  = '{1'b1, 2'd1, 64'h0000_0000_8000_0106, 64'h0000_0000_0000_BEEF, 1'b0, 64'h0,                 1'b1, 8'hC0, 64'hBEEF_0000_0000_0000};
    vecs[1]  = '{1'b0, 2'd1, 64'h0000_0000_8000_0106, 64'h0,                 1'b0, 64'h0000_0000_0000_BEEF, 1'b1, 8'h00, 64'h0};
    vecs[2]  = '{1'b1, 2'd0, 64'h0000_0000_8000_0101, 64'h0000_0000_0000_005A, 1'b0, 64'h0,                 1'b1, 8'h02, 64'h0000_0000_0000_5A00};
    vecs[3]  = '{1'b1, 2'd2, 64'h0000_0000_8000_0104, 64'h0000_0000_1122_3344, 1'b0, 64'h0,                 1'b1, 8'hF0, 64'h1122_3344_0000_0000};
    vecs[4]  = '{1'b0, 2'd3, 64'h0000_0000_8000_0100, 64'h0,                 1'b0, 64'h1122_3344_0000_5A00, 1'b1, 8'h00, 64'h0};
    vecs[5]  = '{1'b0, 2'd0, 64'h0000_0000_8000_0101, 64'h0,                 1'b0, 64'h0000_0000_0000_005A, 1'b1, 8'h00, 64'h0};
    vecs[6]  = '{1'b0, 2'd2, 64'h0000_0000_8000_0104, 64'h0,                 1'b0, 64'h0000_0000_1122_3344, 1'b1, 8'h00, 64'h0};
    vecs[7]  = '{1'b0, 2'd2, 64'h0000_0000_8000_0002, 64'h0,                 1'b1, 64'h0,                 1'b0, 8'h00, 64'h0};
    vecs[8]  = '{1'b1, 2'd3, 64'h0000_0000_8000_0104, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,                 1'b0, 8'h00, 64'h0};
    vecs[9]  = '{1'b0, 2'd1, 64'h0000_0000_8000_0105, 64'h0,                 1'b1, 64'h0,                 1'b0, 8'h00, 64'h0};
    vecs[10] = '{1'b1, 2'd3, 64'h0000_0000_8000_0108, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0,                 1'b1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[11] = '{1'b0, 2'd1, 64'h0000_0000_8000_010E, 64'h0,                 1'b0, 64'h0000_0000_0000_DEAD, 1'b1, 8'h00, 64'h0};
    vecs[12] = '{1'b0, 2'd3, 64'h0000_0000_8000_0100, 64'h0,                 1'b0, 64'h1122_3344_0000_5A00, 1'b1, 8'h00, 64'h0};

    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 64'd0; if_resp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_req_we = 1'b0; lsu_req_size = 2'd0;
    lsu_req_addr = 64'd0; lsu_req_wdata = 64'd0; lsu_resp_ready = 1'b1;
    rr_if_valid = 1'b0; rr_lsu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state, including ready gated off while reset is held
    if_req_valid = 1'b1;
    #1;
    check1("rst_if_req_ready", if_req_ready, 1'b0);
    if_req_valid = 1'b0;
    check64("rst_ctl", 64'({lsu_req_ready, if_resp_valid, if_resp_err, lsu_resp_valid,
                            lsu_resp_err, mem_ce, mem_we}), 64'd0);
    check64("rst_if_inst", 64'(if_resp_inst), 64'd0);
    check64("rst_lsu_rdata", lsu_resp_rdata, 64'd0);
    check64("rst_mem_addr", mem_addr, 64'd0);
    check64("rst_mem_wdata", mem_wdata, 64'd0);
    check64("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // IF fetch from upper word, then misaligned fetch
    c0 = ce_count;
    if_txn(64'h0000_0000_8000_0004, inst, err, lat);
    check64("if_inst", 64'(inst), 64'h0000_0000_0010_0093);
    check1("if_err", err, 1'b0);
    check64("if_latency", 64'(lat), 64'd1);
    check64("if_ce_pulses", 64'(ce_count - c0), 64'd1);
    check64("if_mem_addr", cap_addr, 64'h0000_0000_8000_0000);
    check1("if_mem_we", cap_we, 1'b0);
    c0 = ce_count;
    if_txn(64'h0000_0000_8000_0002, inst, err, lat);
    check1("if_mis_err", err, 1'b1);
    check64("if_mis_inst", 64'(inst), 64'd0);
    check64("if_mis_ce", 64'(ce_count - c0), 64'd0);

    // LSU vector table
    for (int i = 0; i < 13; i++) begin
      c0 = ce_count;
      lsu_txn(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, err, lat);
      check1($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check64($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check64($sformatf("v%0d_ce", i), 64'(ce_count - c0), 64'(vecs[i].exp_ce));
      check64($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_ce));
      if (vecs[i].exp_ce) begin
        check64($sformatf("v%0d_mem_addr", i), cap_addr, vecs[i].addr & ~64'h7);
        check1($sformatf("v%0d_mem_we", i), cap_we, vecs[i].we);
        check64($sformatf("v%0d_wmask", i), 64'(cap_wmask), 64'(vecs[i].exp_mask));
        check64($sformatf("v%0d_mwdata", i), cap_wdata, vecs[i].exp_mwdata);
      end
    end

    // Arbitration: fixed LSU priority, then round-robin
    if_req_addr = 64'h0000_0000_8000_0000;
    lsu_req_we = 1'b0; lsu_req_size = 2'd3; lsu_req_addr = 64'h0000_0000_8000_0100;
    arb_run(1'b0, seq, ng);
    check64("prio_grants", 64'(ng), 64'd8);
    check64("prio_order", 64'(seq), 64'(8'b1111_0000));
    arb_run(1'b1, seq, ng);
    check64("rr_grants", 64'(ng), 64'd8);
    check64("rr_order", 64'(seq), 64'(8'b1010_1010));

    // Response stall with IF waiting
    lsu_resp_ready = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0000;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_size = 2'd3;
    lsu_req_addr = 64'h0000_0000_8000_0108;
    #1;
    check1("stall_lsu_wins", lsu_req_ready, 1'b1);
    check1("stall_if_blocked", if_req_ready, 1'b0);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    check1("stall_resp_valid", lsu_resp_valid, 1'b1);
    held = lsu_resp_rdata;
    ok_valid = 1'b1; ok_stable = 1'b1; ok_ifr = 1'b1;
    repeat (10) begin
      if (!lsu_resp_valid) ok_valid = 1'b0;
      if (lsu_resp_rdata !== held) ok_stable = 1'b0;
      if (if_req_ready) ok_ifr = 1'b0;
      @(posedge clk); #1;
    end
    check1("stall_valid_held", ok_valid, 1'b1);
    check1("stall_data_stable", ok_stable, 1'b1);
    check1("stall_if_ready_low", ok_ifr, 1'b1);
    check64("stall_rdata", held, 64'hDEAD_BEEF_CAFE_F00D);
    lsu_resp_ready = 1'b1;
    @(posedge clk); #1;
    check1("stall_resp_done", lsu_resp_valid, 1'b0);
    check1("stall_if_granted", if_req_ready, 1'b1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    w = 0;
    while (!if_resp_valid && w < 20) begin @(posedge clk); #1; w++; end
    check64("stall_if_inst", 64'(if_resp_inst), 64'h0000_0000_0000_0513);
    @(posedge clk); #1;

    // Reset during ACCESS drops the request
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_size = 2'd3;
    lsu_req_addr = 64'h0000_0000_8000_0100;
    #1;
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    check1("rst_mid_in_access", mem_ce, 1'b1);
    reset = 1'b1; if_req_valid = 1'b1;
    @(posedge clk); #1;
    c0 = ce_count;
    check64("rst_mid_outputs", 64'({mem_ce, mem_we, if_req_ready, lsu_req_ready,
                                    if_resp_valid, lsu_resp_valid}), 64'd0);
    reset = 1'b0; if_req_valid = 1'b0;
    saw_resp = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (lsu_resp_valid || if_resp_valid) saw_resp = 1'b1;
    end
    check1("rst_mid_no_resp", saw_resp, 1'b0);
    check64("rst_mid_no_ce", 64'(ce_count - c0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
